countdown_timer: RTL and testbench

- Game countdown timer for the Saper game. It is the decrementing counterpart of the event up-counter.
- Loads a preset number of seconds and decrements once per second derived from clk. It can be started, paused and resumed.
- Outputs remaining time in binary and as 3-digit BCD for the on-screen display, plus a one-cycle expiry pulse for the game control FSM (loss on timeout).

---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Saper game countdown timer: loads a preset number of seconds, counts down once per
// second while running, and reports the remaining time in binary and BCD plus an expiry pulse.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 65_000_000,
    parameter int DATA_SIZE     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] preset,
    input  logic                 start,
    input  logic                 pause,
    output logic [DATA_SIZE-1:0] time_left,
    output logic [11:0]          bcd,
    output logic                 running,
    output logic                 expired,
    output logic                 zero,
    output logic [1:0]           state_dbg
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]        PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [DATA_SIZE-1:0] MAX_TIME   = DATA_SIZE'(999);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [DATA_SIZE-1:0] time_q, time_d;
    logic [11:0]          bcd_q, bcd_d;
    logic                 running_q;
    logic                 expired_q, expired_d;
    logic                 load_hist_q, start_hist_q, pause_hist_q;

    logic load_edge, start_edge, pause_edge;

    assign load_edge  = load  & ~load_hist_q;
    assign start_edge = start & ~start_hist_q;
    assign pause_edge = pause & ~pause_hist_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        time_d    = time_q;
        expired_d = 1'b0;

        // load overrides everything; pause beats start when both rise together
        if (load_edge) begin
            time_d  = (preset > MAX_TIME) ? MAX_TIME : preset;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge && !pause_edge && (time_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause_edge) begin
                        state_d = PAUSED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (time_q != '0) begin
                            time_d = time_q - DATA_SIZE'(1);
                        end
                        if (time_q == DATA_SIZE'(1)) begin
                            expired_d = 1'b1;
                            state_d   = EXPIRED;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start_edge && !pause_edge) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Double-dabble over the current time; the result is registered one cycle later.
    logic [DATA_SIZE+11:0] dd;
    always_comb begin
        dd                  = '0;
        dd[DATA_SIZE-1:0]   = time_q;
        for (int i = 0; i < DATA_SIZE; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (dd[DATA_SIZE + 4*d +: 4] >= 4'd5) begin
                    dd[DATA_SIZE + 4*d +: 4] = dd[DATA_SIZE + 4*d +: 4] + 4'd3;
                end
            end
            dd = dd << 1;
        end
        bcd_d = dd[DATA_SIZE+11:DATA_SIZE];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            time_q       <= '0;
            bcd_q        <= '0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            load_hist_q  <= 1'b0;
            start_hist_q <= 1'b0;
            pause_hist_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            time_q       <= time_d;
            bcd_q        <= bcd_d;
            running_q    <= (state_d == RUN);
            expired_q    <= expired_d;
            load_hist_q  <= load;
            start_hist_q <= start;
            pause_hist_q <= pause;
        end
    end

    assign time_left = time_q;
    assign bcd       = bcd_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign zero      = (time_q == '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by random level activity,
// each cycle compared against a seconds-elapsed model of the timer.
module tb_countdown_timer;

  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [9:0] preset;
  logic       start;
  logic       pause;
  logic [9:0] time_left;
  logic [11:0] bcd;
  logic       running;
  logic       expired;
  logic       zero;
  logic [1:0] state_dbg;

  countdown_timer #(
    .TICKS_PER_SEC(T),
    .DATA_SIZE(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .preset(preset),
    .start(start),
    .pause(pause),
    .time_left(time_left),
    .bcd(bcd),
    .running(running),
    .expired(expired),
    .zero(zero),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // driven levels
  logic       d_load = 1'b0;
  logic       d_start = 1'b0;
  logic       d_pause = 1'b0;
  logic       d_rst = 1'b0;
  logic [9:0] d_preset = '0;

  // reference model: remaining time = loaded seconds - whole seconds of run time
  int         m_loaded = 0;
  int         m_cycles = 0;
  int         m_time = 0;
  bit         m_run = 1'b0;
  bit         m_done = 1'b0;
  bit         m_exp = 1'b0;
  logic [11:0] m_bcd = '0;
  bit         m_pl = 1'b0;
  bit         m_ps = 1'b0;
  bit         m_pp = 1'b0;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    bit le, se, pe;
    if (d_rst) begin
      m_loaded = 0; m_cycles = 0; m_time = 0;
      m_run = 0; m_done = 0; m_exp = 0; m_bcd = '0;
      m_pl = 0; m_ps = 0; m_pp = 0;
    end else begin
      le = d_load & ~m_pl;
      se = d_start & ~m_ps;
      pe = d_pause & ~m_pp;
      m_pl = d_load; m_ps = d_start; m_pp = d_pause;
      m_bcd = to_bcd(m_time);
      m_exp = 0;
      if (le) begin
        m_loaded = (d_preset > 999) ? 999 : int'(d_preset);
        m_cycles = 0;
        m_run = 0;
        m_done = 0;
      end else if (m_run) begin
        if (pe) begin
          m_run = 0;
        end else begin
          m_cycles++;
          if (m_loaded - m_cycles / T == 0) begin
            m_exp = 1;
            m_run = 0;
            m_done = 1;
          end
        end
      end else if (!m_done && se && !pe && m_time > 0) begin
        m_run = 1;
      end
      m_time = m_loaded - m_cycles / T;
    end
  endtask

  // driver: apply current levels for n cycles, checking all outputs after each edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      load = d_load; start = d_start; pause = d_pause; rst = d_rst; preset = d_preset;
      @(posedge clk);
      model_step();
      #1;
      check("time_left", 16'(time_left), 16'(m_time));
      check("bcd", 16'(bcd), 16'(m_bcd));
      check("running", 16'(running), 16'(m_run));
      check("expired", 16'(expired), 16'(m_exp));
      check("zero", 16'(zero), 16'(m_time == 0));
    end
  endtask

  task automatic pulse_load(input logic [9:0] p);
    d_preset = p; d_load = 1'b1; run(1); d_load = 1'b0;
  endtask

  task automatic pulse_start();
    d_start = 1'b1; run(1); d_start = 1'b0;
  endtask

  int exp_count;

  initial begin
    load = 0; start = 0; pause = 0; rst = 1; preset = '0;
    d_rst = 1'b1; run(2);
    d_rst = 1'b0; run(2);

    // basic countdown from 3 with expiry
    pulse_load(10'd3); run(1);
    pulse_start();
    exp_count = 0;
    for (int i = 0; i < 16; i++) begin
      run(1);
      if (expired) exp_count++;
    end
    check("expiry_pulses", 16'(exp_count), 16'd1);
    check("final_bcd", 16'(bcd), 16'h000);

    // pause and resume from a partially advanced prescaler
    pulse_load(10'd10);
    pulse_start();
    run(6);
    d_pause = 1'b1; run(1); d_pause = 1'b0;
    check("paused_time", 16'(time_left), 16'd9);
    run(20);
    check("pause_hold", 16'(time_left), 16'd9);
    pulse_start();
    run(1);
    check("resume_pre", 16'(time_left), 16'd9);
    run(1);
    check("resume_dec", 16'(time_left), 16'd8);
    run(8);

    // saturation of oversized preset
    pulse_load(10'd1023);
    check("sat_time", 16'(time_left), 16'd999);
    run(1);
    check("sat_bcd", 16'(bcd), 16'h999);
    pulse_start();
    run(5);
    check("sat_tick", 16'(time_left), 16'd998);
    run(1);
    check("sat_tick_bcd", 16'(bcd), 16'h998);

    // start with zero time after reset
    d_rst = 1'b1; run(1); d_rst = 1'b0;
    pulse_start();
    run(10);
    check("zero_start_run", 16'(running), 16'd0);

    // load and start together mid-run, then held start
    pulse_load(10'd5);
    pulse_start();
    run(3);
    d_preset = 10'd5; d_load = 1'b1; d_start = 1'b1; run(1); d_load = 1'b0;
    check("load_wins", 16'(running), 16'd0);
    run(50);
    check("held_start", 16'(running), 16'd0);
    d_start = 1'b0; run(1);
    d_start = 1'b1; run(1);
    check("restart", 16'(running), 16'd1);
    d_start = 1'b0; run(5);

    // reset in the middle of a countdown
    pulse_load(10'd5);
    pulse_start();
    for (int k = 0; k < 100 && m_time != 2; k++) run(1);
    check("reach_two", 16'(time_left), 16'd2);
    d_rst = 1'b1; run(1); d_rst = 1'b0;
    check("rst_zero", 16'(zero), 16'd1);
    run(10);

    // random level activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) d_load = ~d_load;
      if ($urandom_range(0, 5) == 0) d_start = ~d_start;
      if ($urandom_range(0, 11) == 0) d_pause = ~d_pause;
      d_rst = ($urandom_range(0, 299) == 0);
      d_preset = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, 6));
      run(1);
    end
    d_rst = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
